// File: rtl/prog_prio_wrr_arbiter.sv
// Registered N-way arbiter with programmable-priority, round-robin and weighted
// round-robin modes; a winner owns the grant for up to its beat quota.
module prog_prio_wrr_arbiter #(
  parameter  int N  = 4,
  parameter  int WW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
  input  logic [1:0]        mode_i,
  input  logic [N-1:0]      req_i,
  input  logic [N*IW-1:0]   prio_map_i,
  input  logic [N*WW-1:0]   weight_i,
  output logic [N-1:0]      grant_o,
  output logic [IW-1:0]     grant_id_o,
  output logic              grant_vld_o
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic            grant_vld_q, grant_vld_d;
  logic [WW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WW-1:0]   quota_q, quota_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

  logic            rr_mode_s;
  logic            win_vld_s;
  logic [IW-1:0]   win_id_s;
  logic [WW-1:0]   win_weight_s;
  logic [WW-1:0]   win_quota_s;
  logic            owner_req_s;
  logic            release_s;

  assign rr_mode_s = (mode_i == 2'b01) || (mode_i == 2'b10);

  // Winner search: rank scan in priority mode, rotating scan from rr_ptr+1 otherwise.
  always_comb begin
    logic [IW-1:0] cand;
    win_vld_s = 1'b0;
    win_id_s  = '0;
    cand      = '0;
    if (rr_mode_s) begin
      for (int i = 1; i <= N; i++) begin
        cand = IW'((int'(rr_ptr_q) + i) % N);
        if (!win_vld_s && req_i[cand]) begin
          win_vld_s = 1'b1;
          win_id_s  = cand;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = prio_map_i[k*IW +: IW];
        if (!win_vld_s && (int'(cand) < N) && req_i[cand]) begin
          win_vld_s = 1'b1;
          win_id_s  = cand;
        end
      end
    end
  end

  assign win_weight_s = weight_i[int'(win_id_s)*WW +: WW];
  assign win_quota_s  = (mode_i == 2'b01 || win_weight_s == '0) ? WW'(1) : win_weight_s;
  assign owner_req_s  = |(req_i & grant_q);
  assign release_s    = !owner_req_s || (beat_cnt_q == quota_q);

  // Next-state: hold, extend the burst, or re-arbitrate (zero-bubble hand-over).
  always_comb begin
    logic arb;
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    quota_d     = quota_q;
    rr_ptr_d    = rr_ptr_q;
    arb         = 1'b0;
    case (state_q)
      IDLE:    arb = 1'b1;
      OWN:     arb = release_s;
      default: arb = 1'b1;
    endcase
    if (!en_i) begin
      state_d    = IDLE;
      grant_d    = '0;
      beat_cnt_d = '0;
    end else if (arb) begin
      if (win_vld_s) begin
        state_d    = OWN;
        grant_d    = {{(N-1){1'b0}}, 1'b1} << win_id_s;
        grant_id_d = win_id_s;
        beat_cnt_d = WW'(1);
        quota_d    = win_quota_s;
        if (rr_mode_s) begin
          rr_ptr_d = win_id_s;
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end else begin
        state_d    = IDLE;
        grant_d    = '0;
        beat_cnt_d = '0;
      end
    end else begin
      beat_cnt_d = beat_cnt_q + WW'(1);
    end
    grant_vld_d = |grant_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      grant_vld_q <= 1'b0;
      beat_cnt_q  <= '0;
      quota_q     <= '0;
      rr_ptr_q    <= IW'(N - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      grant_vld_q <= grant_vld_d;
      beat_cnt_q  <= beat_cnt_d;
      quota_q     <= quota_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_id_o  = grant_id_q;
  assign grant_vld_o = grant_vld_q;

endmodule

// File: tb/tb_prog_prio_wrr_arbiter.sv
// Bench for prog_prio_wrr_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural model.
module tb_prog_prio_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [1:0]  mode;
  logic [3:0]  req;
  logic [7:0]  prio_map;
  logic [15:0] weight;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        grant_vld;

  int errors = 0;
  int checks = 0;

  prog_prio_wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en_i        (en),
    .mode_i      (mode),
    .req_i       (req),
    .prio_map_i  (prio_map),
    .weight_i    (weight),
    .grant_o     (grant),
    .grant_id_o  (grant_id),
    .grant_vld_o (grant_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  req;
    logic [7:0]  prio;
    logic [15:0] wt;
    logic [3:0]  eg;
    logic [1:0]  eid;
    logic        ev;
  } vec_t;

  vec_t vecs[14];

  // Behavioural model state: owner index (-1 = none), beats used, quota, RR pointer.
  int m_owner, m_beats, m_quota, m_ptr, m_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] eg, input logic [1:0] eid,
                           input logic ev);
    check({name, ".grant"}, 32'(grant), 32'(eg));
    check({name, ".id"}, 32'(grant_id), 32'(eid));
    check({name, ".vld"}, 32'(grant_vld), 32'(ev));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    m_owner = -1; m_beats = 0; m_quota = 0; m_ptr = N - 1; m_id = 0;
  endtask

  function automatic int m_pick();
    if (mode == 2'b01 || mode == 2'b10) begin
      for (int i = 1; i <= N; i++) begin
        int c = (m_ptr + i) % N;
        if (req[c]) return c;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int p = int'(prio_map[k*2 +: 2]);
        if (req[p]) return p;
      end
    end
    return -1;
  endfunction

  function automatic void m_step();
    int w;
    if (!en) begin
      m_owner = -1;
      m_beats = 0;
    end else if (m_owner < 0 || !req[m_owner] || m_beats == m_quota) begin
      w = m_pick();
      if (w >= 0) begin
        m_owner = w;
        m_id    = w;
        m_beats = 1;
        m_quota = (mode == 2'b01) ? 1 : int'(weight[w*4 +: 4]);
        if (m_quota == 0) m_quota = 1;
        if (mode == 2'b01 || mode == 2'b10) m_ptr = w;
      end else begin
        m_owner = -1;
        m_beats = 0;
      end
    end else begin
      m_beats++;
    end
  endfunction

  int wrr_ids[8] = '{0, 0, 0, 1, 2, 2, 3, 0};
  int er_ids[5]  = '{1, 1, 1, 1, 0};
  int en_ids[4]  = '{2, 2, 2, 0};

  initial begin
    logic [3:0] eg;
    // Directed table: priority mode, RR with sparse requests, excluded requesters, en=0.
    vecs[0]  = '{1'b1, 2'b00, 4'b1111, 8'h72, 16'h1111, 4'b0100, 2'd2, 1'b1};
    vecs[1]  = '{1'b1, 2'b00, 4'b1111, 8'h72, 16'h1111, 4'b0100, 2'd2, 1'b1};
    vecs[2]  = '{1'b1, 2'b00, 4'b1011, 8'h72, 16'h1111, 4'b0001, 2'd0, 1'b1};
    vecs[3]  = '{1'b1, 2'b00, 4'b1011, 8'h72, 16'h1111, 4'b0001, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 2'b01, 4'b1010, 8'h72, 16'h1111, 4'b0010, 2'd1, 1'b1};
    vecs[5]  = '{1'b1, 2'b01, 4'b1010, 8'h72, 16'h1111, 4'b1000, 2'd3, 1'b1};
    vecs[6]  = '{1'b1, 2'b01, 4'b1010, 8'h72, 16'h1111, 4'b0010, 2'd1, 1'b1};
    vecs[7]  = '{1'b1, 2'b01, 4'b1010, 8'h72, 16'h1111, 4'b1000, 2'd3, 1'b1};
    vecs[8]  = '{1'b1, 2'b01, 4'b0000, 8'h72, 16'h1111, 4'b0000, 2'd3, 1'b0};
    vecs[9]  = '{1'b1, 2'b00, 4'b1100, 8'h50, 16'h1111, 4'b0000, 2'd3, 1'b0};
    vecs[10] = '{1'b1, 2'b00, 4'b1100, 8'h50, 16'h1111, 4'b0000, 2'd3, 1'b0};
    vecs[11] = '{1'b1, 2'b00, 4'b1101, 8'h50, 16'h1111, 4'b0001, 2'd0, 1'b1};
    vecs[12] = '{1'b0, 2'b00, 4'b1101, 8'h50, 16'h1111, 4'b0000, 2'd0, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 4'b1101, 8'h50, 16'h1111, 4'b0000, 2'd0, 1'b0};

    en = 1'b1; mode = 2'b00; req = 4'b0000; prio_map = 8'h72; weight = 16'h1111;
    rstn = 1'b0;
    #2;
    check_out("reset", 4'b0000, 2'd0, 1'b0);
    do_reset();
    check_out("post_reset", 4'b0000, 2'd0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; req = vecs[i].req;
      prio_map = vecs[i].prio; weight = vecs[i].wt;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eid, vecs[i].ev);
    end

    // Weighted RR, all requesting: no idle cycles between owners.
    do_reset();
    en = 1'b1; mode = 2'b10; weight = 16'h1213; req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_out($sformatf("wrr%0d", i), 4'(1 << wrr_ids[i]), 2'(wrr_ids[i]), 1'b1);
    end

    // Early release then fresh 5-beat quota on regrant.
    do_reset();
    mode = 2'b10; weight = 16'h0050; req = 4'b0010;
    tick(); check_out("er_b1", 4'b0010, 2'd1, 1'b1);
    tick(); check_out("er_b2", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    tick(); check_out("er_drop", 4'b0000, 2'd1, 1'b0);
    req = 4'b0010;
    tick(); check_out("er_regrant", 4'b0010, 2'd1, 1'b1);
    req = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("er_q%0d", i), 4'(1 << er_ids[i]), 2'(er_ids[i]), 1'b1);
    end

    // en dropped mid-burst, then fresh 4-beat quota.
    do_reset();
    mode = 2'b10; weight = 16'h0400; req = 4'b0100;
    tick(); check_out("en_b1", 4'b0100, 2'd2, 1'b1);
    tick(); check_out("en_b2", 4'b0100, 2'd2, 1'b1);
    en = 1'b0;
    tick(); check_out("en_off", 4'b0000, 2'd2, 1'b0);
    tick(); check_out("en_off_hold", 4'b0000, 2'd2, 1'b0);
    en = 1'b1;
    tick(); check_out("en_regrant", 4'b0100, 2'd2, 1'b1);
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("en_q%0d", i), 4'(1 << en_ids[i]), 2'(en_ids[i]), 1'b1);
    end

    // Asynchronous reset mid-burst; rr_ptr must return so requester 0 is first.
    mode = 2'b10; weight = 16'h0400; req = 4'b0100;
    tick(); tick();
    #3 rstn = 1'b0;
    #1 check_out("async_rst", 4'b0000, 2'd0, 1'b0);
    tick();
    rstn = 1'b1; mode = 2'b01; req = 4'b1111;
    tick(); check_out("rst_rr_first", 4'b0001, 2'd0, 1'b1);
    tick(); check_out("rst_rr_second", 4'b0010, 2'd1, 1'b1);

    // Randomized traffic against the model.
    do_reset();
    en = 1'b1; mode = 2'($urandom_range(0, 3));
    prio_map = 8'($urandom); weight = 16'($urandom); req = 4'($urandom);
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) prio_map = 8'($urandom);
      if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
      m_step();
      tick();
      eg = 4'b0000;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      check_out($sformatf("rnd%0d", c), eg, 2'(m_id), (m_owner >= 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
